inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 90 +++++++++
 tb/tb_inst_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: assembles a serial byte stream into 32-bit words and writes them to instruction memory
// Ports:
//   clk, rst          - clock and synchronous active-low reset
//   i_start           - one-cycle pulse that begins a program load (from IDLE or DONE)
//   i_rx_data/valid   - incoming program byte, big-endian within each word
//   o_write_inst_mem  - one-cycle write strobe
//   o_inst_mem_addr   - word address being written
//   o_inst_mem_data   - word being written
//   o_enable          - datapath run enable, high once the program is loaded
//   o_busy            - high while loading (LOAD or WRITE)
//   o_done            - high once loading has finished
//   o_overflow        - sticky flag, set when the address space is exhausted before HALT
module inst_loader #(
    parameter int PC_BITS = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter logic [INSTRUCTION_BITS-1:0] HALT_INST = 32'hFC000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_valid,
    output logic                        o_write_inst_mem,
    output logic [PC_BITS-1:0]          o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
    output logic                        o_enable,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    state_t                        r_state, w_next;
    logic [INSTRUCTION_BITS-1:0]   r_word, r_data;
    logic [1:0]                    r_cnt;
    logic [PC_BITS-1:0]            r_addr;
    logic                          r_overflow;
    logic                          w_accept, w_restart, w_halt, w_last;
    // Bytes are taken in WRITE too, so the shift register keeps running while
    // r_data holds the completed word being written.
    assign w_accept  = i_rx_valid && (r_state == LOAD || r_state == WRITE);
    assign w_restart = i_start && (r_state == IDLE || r_state == DONE);
    assign w_halt    = r_data == HALT_INST;
    assign w_last    = &r_addr;
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? LOAD : IDLE;
            LOAD:    w_next = (w_accept && r_cnt == 2'd3) ? WRITE : LOAD;
            WRITE:   w_next = (w_halt || w_last) ? DONE : LOAD;
            DONE:    w_next = i_start ? LOAD : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_restart) begin
                r_cnt      <= '0;
                r_addr     <= '0;
                r_overflow <= 1'b0;
            end else if (w_accept) begin
                r_word <= {r_word[INSTRUCTION_BITS-9:0], i_rx_data};
                r_cnt  <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) r_data <= {r_word[INSTRUCTION_BITS-9:0], i_rx_data};
            end
            if (r_state == WRITE) begin
                r_addr <= r_addr + PC_BITS'(1);
                if (w_last && !w_halt) r_overflow <= 1'b1;
            end
        end
    end
    always_comb begin
        o_write_inst_mem = r_state == WRITE;
        o_busy           = r_state == LOAD || r_state == WRITE;
        o_done           = r_state == DONE;
        o_enable         = r_state == DONE;
        o_inst_mem_addr  = r_addr;
        o_inst_mem_data  = r_data;
        o_overflow       = r_overflow;
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader (default and PC_BITS=2 instances)
module tb_inst_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        w0, en0, busy0, done0, ovf0;
    logic [31:0] addr0, data0;
    logic        w1, en1, busy1, done1, ovf1;
    logic [1:0]  addr1;
    logic [31:0] data1;
    logic [31:0] a0 [64];
    logic [31:0] d0 [64];
    logic [1:0]  a1 [64];
    logic [31:0] d1 [64];
    int n0 = 0, n1 = 0;
    int n_tests = 0, n_fail = 0;

    inst_loader dut0 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_write_inst_mem(w0), .o_inst_mem_addr(addr0), .o_inst_mem_data(data0),
        .o_enable(en0), .o_busy(busy0), .o_done(done0), .o_overflow(ovf0)
    );
    inst_loader #(.PC_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_write_inst_mem(w1), .o_inst_mem_addr(addr1), .o_inst_mem_data(data1),
        .o_enable(en1), .o_busy(busy1), .o_done(done1), .o_overflow(ovf1)
    );

    always #5 clk = ~clk;

    // write logger, sampled mid-cycle
    always @(negedge clk) begin
        if (w0 && n0 < 64) begin a0[n0] = addr0; d0[n0] = data0; n0++; end
        if (w1 && n1 < 64) begin a1[n1] = addr1; d1[n1] = data1; n1++; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data = b;
        tick();
        i_rx_valid = 1'b0;
    endtask

    // returns with the DUT in the WRITE cycle of this word
    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) begin
            send(w[i*8 +: 8]);
            if (i != 0) for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_tests++; if (w0 !== 1'b0) begin $display("FAIL reset_write got %b exp 0", w0); n_fail++; end
        n_tests++; if (addr0 !== 32'h0) begin $display("FAIL reset_addr got %h exp 0", addr0); n_fail++; end
        n_tests++; if (data0 !== 32'h0) begin $display("FAIL reset_data got %h exp 0", data0); n_fail++; end
        n_tests++; if ({en0, busy0, done0, ovf0} !== 4'b0) begin $display("FAIL reset_flags got %b exp 0000", {en0, busy0, done0, ovf0}); n_fail++; end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int base;
        do_reset();
        base = n0;
        pulse_start();
        send_word(32'h20010005, 1);
        n_tests++; if (w0 !== 1'b1 || addr0 !== 32'd0) begin $display("FAIL basic_latency0 got w=%b a=%h exp w=1 a=0", w0, addr0); n_fail++; end
        tick();
        send_word(32'hFC000000, 2);
        n_tests++; if (w0 !== 1'b1 || addr0 !== 32'd1) begin $display("FAIL basic_latency1 got w=%b a=%h exp w=1 a=1", w0, addr0); n_fail++; end
        tick();
        n_tests++; if (done0 !== 1'b1 || en0 !== 1'b1 || busy0 !== 1'b0) begin $display("FAIL basic_done got d=%b e=%b b=%b exp 1 1 0", done0, en0, busy0); n_fail++; end
        n_tests++; if (n0 - base !== 2) begin $display("FAIL basic_count got %0d exp 2", n0 - base); n_fail++; end
        n_tests++; if (a0[base] !== 32'd0 || d0[base] !== 32'h20010005) begin $display("FAIL basic_w0 got %h:%h exp 0:20010005", a0[base], d0[base]); n_fail++; end
        n_tests++; if (a0[base+1] !== 32'd1 || d0[base+1] !== 32'hFC000000) begin $display("FAIL basic_w1 got %h:%h exp 1:fc000000", a0[base+1], d0[base+1]); n_fail++; end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = n0;
        pulse_start();
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(32'h99AABBCC, 0);
        tick();
        tick();
        n_tests++; if (n0 - base !== 3) begin $display("FAIL b2b_count got %0d exp 3", n0 - base); n_fail++; end
        n_tests++; if (a0[base] !== 32'd0 || d0[base] !== 32'h11223344) begin $display("FAIL b2b_w0 got %h:%h exp 0:11223344", a0[base], d0[base]); n_fail++; end
        n_tests++; if (a0[base+1] !== 32'd1 || d0[base+1] !== 32'h55667788) begin $display("FAIL b2b_w1 got %h:%h exp 1:55667788", a0[base+1], d0[base+1]); n_fail++; end
        n_tests++; if (a0[base+2] !== 32'd2 || d0[base+2] !== 32'h99AABBCC) begin $display("FAIL b2b_w2 got %h:%h exp 2:99aabbcc", a0[base+2], d0[base+2]); n_fail++; end
        n_tests++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin $display("FAIL b2b_state got b=%b d=%b exp 1 0", busy0, done0); n_fail++; end
    endtask

    task automatic test_reset_midload();
        int base;
        do_reset();
        base = n0;
        pulse_start();
        send(8'hAB);
        send(8'hCD);
        rst = 1'b0;
        tick();
        n_tests++; if (busy0 !== 1'b0 || w0 !== 1'b0) begin $display("FAIL midrst_idle got b=%b w=%b exp 0 0", busy0, w0); n_fail++; end
        rst = 1'b1;
        pulse_start();
        send_word(32'hFC000000, 1);
        tick();
        n_tests++; if (n0 - base !== 1) begin $display("FAIL midrst_count got %0d exp 1", n0 - base); n_fail++; end
        n_tests++; if (a0[base] !== 32'd0 || d0[base] !== 32'hFC000000) begin $display("FAIL midrst_w0 got %h:%h exp 0:fc000000", a0[base], d0[base]); n_fail++; end
        n_tests++; if (done0 !== 1'b1) begin $display("FAIL midrst_done got %b exp 1", done0); n_fail++; end
    endtask

    task automatic test_overflow();
        int base;
        logic [7:0] k;
        do_reset();
        base = n1;
        pulse_start();
        for (int i = 1; i <= 5; i++) begin
            k = 8'(i);
            send_word({4{k}}, 0);
        end
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if (n1 - base !== 4) begin $display("FAIL ovf_count got %0d exp 4", n1 - base); n_fail++; end
        n_tests++; if (a1[base] !== 2'd0 || d1[base] !== 32'h01010101) begin $display("FAIL ovf_w0 got %h:%h exp 0:01010101", a1[base], d1[base]); n_fail++; end
        n_tests++; if (a1[base+3] !== 2'd3 || d1[base+3] !== 32'h04040404) begin $display("FAIL ovf_w3 got %h:%h exp 3:04040404", a1[base+3], d1[base+3]); n_fail++; end
        n_tests++; if (ovf1 !== 1'b1 || done1 !== 1'b1 || en1 !== 1'b1) begin $display("FAIL ovf_flags got o=%b d=%b e=%b exp 1 1 1", ovf1, done1, en1); n_fail++; end
        n_tests++; if (ovf0 !== 1'b0) begin $display("FAIL ovf_wide got %b exp 0", ovf0); n_fail++; end
    endtask

    task automatic test_restart();
        int base;
        do_reset();
        pulse_start();
        send_word(32'hFC000000, 0);
        tick();
        n_tests++; if (en0 !== 1'b1 || done0 !== 1'b1) begin $display("FAIL rs_done got e=%b d=%b exp 1 1", en0, done0); n_fail++; end
        pulse_start();
        n_tests++; if (en0 !== 1'b0 || busy0 !== 1'b1 || done0 !== 1'b0) begin $display("FAIL rs_enable got e=%b b=%b d=%b exp 0 1 0", en0, busy0, done0); n_fail++; end
        base = n0;
        send_word(32'h12345678, 0);
        tick();
        send_word(32'hFC000000, 0);
        tick();
        n_tests++; if (n0 - base !== 2) begin $display("FAIL rs_count got %0d exp 2", n0 - base); n_fail++; end
        n_tests++; if (a0[base] !== 32'd0 || d0[base] !== 32'h12345678) begin $display("FAIL rs_w0 got %h:%h exp 0:12345678", a0[base], d0[base]); n_fail++; end
        n_tests++; if (a0[base+1] !== 32'd1 || d0[base+1] !== 32'hFC000000) begin $display("FAIL rs_w1 got %h:%h exp 1:fc000000", a0[base+1], d0[base+1]); n_fail++; end
    endtask

    task automatic test_ignore();
        int base;
        do_reset();
        base = n0;
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        n_tests++; if (busy0 !== 1'b0 || n0 != base) begin $display("FAIL ign_idle got b=%b n=%0d exp 0 0", busy0, n0 - base); n_fail++; end
        pulse_start();
        send_word(32'hFC000000, 1);
        tick();
        n_tests++; if (n0 - base !== 1 || d0[base] !== 32'hFC000000) begin $display("FAIL ign_idle_word got n=%0d d=%h exp 1 fc000000", n0 - base, d0[base]); n_fail++; end
        send_word(32'h11223344, 0);
        tick();
        tick();
        n_tests++; if (n0 - base !== 1 || done0 !== 1'b1) begin $display("FAIL ign_done got n=%0d d=%b exp 1 1", n0 - base, done0); n_fail++; end
        pulse_start();
        send_word(32'hFC000000, 0);
        tick();
        n_tests++; if (n0 - base !== 2 || a0[base+1] !== 32'd0 || d0[base+1] !== 32'hFC000000) begin $display("FAIL ign_after got n=%0d %h:%h exp 2 0:fc000000", n0 - base, a0[base+1], d0[base+1]); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_midload();
        test_overflow();
        test_restart();
        test_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
